cp0_exception_unit: RTL

Coprocessor-0 exception/interrupt responder sitting beside the MEM stage. It consumes the per-instruction exception code and delay-slot flag that the EX/MEM register produces, together with external hardware interrupt lines. It arbitrates them, commits exception state (SR/Cause/EPC), and raises a flush/redirect request to the pipeline. It also serves mfc0/mtc0/eret accesses issued from the MEM stage.

---
 rtl/cp0_exception_unit.sv | 110 +++++++++++
 1 files changed

// File: rtl/cp0_exception_unit.sv
// CP0 exception/interrupt responder beside the MEM stage: arbitrates interrupts and exceptions,
// commits SR/Cause/EPC and serves mfc0/mtc0/eret.
module cp0_exception_unit #(
  parameter logic [31:0] PRID       = 32'h0000_7EA7,
  parameter logic [31:0] HANDLER_PC = 32'h0000_4180
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m_valid,
  input  logic [31:0] pc_m,
  input  logic [4:0]  exc_code_m,
  input  logic        delay_slot_m,
  input  logic [5:0]  hw_int,
  input  logic        cp0_we,
  input  logic [4:0]  cp0_addr,
  input  logic [31:0] cp0_wdata,
  input  logic        eret_m,
  output logic [31:0] cp0_rdata,
  output logic [31:0] epc,
  output logic        exc_req,
  output logic [31:0] handler_pc
);

  localparam logic [4:0] AddrSr    = 5'd12;
  localparam logic [4:0] AddrCause = 5'd13;
  localparam logic [4:0] AddrEpc   = 5'd14;
  localparam logic [4:0] AddrPrid  = 5'd15;

  logic [5:0]  sr_im_q;
  logic        sr_exl_q;
  logic        sr_ie_q;
  logic        cause_bd_q;
  logic [5:0]  cause_ip_q;
  logic [4:0]  cause_exc_q;
  logic [31:0] epc_q;

  logic        int_pend;
  logic        exc_pend;
  logic [4:0]  rec_code;
  logic [31:0] epc_target;
  logic        sr_write;
  logic        epc_write;
  logic        eret_commit;
  logic [31:0] sr_word;
  logic [31:0] cause_word;

  // Interrupt sampling uses the live lines, not the registered IP copy.
  assign int_pend = sr_ie_q & ~sr_exl_q & (|(hw_int & sr_im_q)) & m_valid;
  assign exc_pend = (exc_code_m != 5'd0) & ~sr_exl_q & m_valid;
  assign exc_req  = int_pend | exc_pend;

  assign rec_code   = int_pend ? 5'd0 : exc_code_m;
  assign epc_target = delay_slot_m ? (pc_m - 32'd4) : pc_m;

  // A faulting instruction's own mtc0/eret must not take effect.
  assign sr_write    = cp0_we & ~exc_req & (cp0_addr == AddrSr);
  assign epc_write   = cp0_we & ~exc_req & (cp0_addr == AddrEpc);
  assign eret_commit = eret_m & ~exc_req;

  assign sr_word    = {16'd0, sr_im_q, 8'd0, sr_exl_q, sr_ie_q};
  assign cause_word = {cause_bd_q, 15'd0, cause_ip_q, 3'd0, cause_exc_q, 2'd0};

  always_comb begin
    cp0_rdata = 32'd0;
    unique case (cp0_addr)
      AddrSr:    cp0_rdata = sr_word;
      AddrCause: cp0_rdata = cause_word;
      AddrEpc:   cp0_rdata = epc_q;
      AddrPrid:  cp0_rdata = PRID;
      default:   cp0_rdata = 32'd0;
    endcase
  end

  assign epc        = epc_q;
  assign handler_pc = HANDLER_PC;

  always_ff @(posedge clk) begin
    if (reset) begin
      sr_im_q     <= 6'd0;
      sr_exl_q    <= 1'b0;
      sr_ie_q     <= 1'b0;
      cause_bd_q  <= 1'b0;
      cause_ip_q  <= 6'd0;
      cause_exc_q <= 5'd0;
      epc_q       <= 32'd0;
    end else begin
      cause_ip_q <= hw_int;
      if (exc_req) begin
        sr_exl_q    <= 1'b1;
        cause_exc_q <= rec_code;
        cause_bd_q  <= delay_slot_m;
        epc_q       <= epc_target;
      end else begin
        if (sr_write) begin
          sr_im_q  <= cp0_wdata[15:10];
          sr_exl_q <= cp0_wdata[1];
          sr_ie_q  <= cp0_wdata[0];
        end
        if (epc_write) begin
          epc_q <= cp0_wdata;
        end
        // eret's EXL clear overrides an mtc0-written EXL in the same cycle.
        if (eret_commit) begin
          sr_exl_q <= 1'b0;
        end
      end
    end
  end

endmodule
